imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a little-endian byte stream and packs it into 32-bit words.
- Writes the words into the instruction memory write port, starting at a programmable word address.
- Used at boot or debug time to load the program that the fetch stage later reads at word index pc[31:2].
- Holds the core in reset via core_hold while loading.

Parameters:
- ADDR_W, 10, word-address width; instruction memory depth = 2**ADDR_W words (1024).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load; sampled only in IDLE
- base_word  input  ADDR_W  first word index to write; sampled with start
- num_words  input  ADDR_W+1  number of words to load, 0..1024; sampled with start
- s_valid  input  1  byte stream valid
- s_data  input  8  byte stream data
- s_ready  output  1  byte accepted when s_valid && s_ready
- mem_we  output  1  instruction memory write enable
- mem_waddr  output  ADDR_W  word index
- mem_wdata  output  32  word data
- busy  output  1  high in LOAD and WRITE
- core_hold  output  1  high in LOAD, WRITE and DONE
- done  output  1  one-cycle pulse at load completion

Behaviour:
- Reset (rst high at a clock edge) sets state IDLE, byte_idx=0, word register=0, address=0, words_left=0.
- All outputs are 0 after reset: s_ready, mem_we, mem_waddr, mem_wdata, busy, core_hold, done.
- Reset wins over every other input on the same edge.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - s_ready=0.
  - On start: latch address=base_word and words_left=num_words.
  - If num_words==0, go to DONE; else go to LOAD with byte_idx=0.
- LOAD:
  - s_ready=1.
  - On handshake, s_data goes into word bits [8*byte_idx+7 : 8*byte_idx] (little-endian: first byte lands in [7:0]), then byte_idx increments.
  - Handshake at byte_idx==3 sets byte_idx=0 and goes to WRITE.
  - With no handshake, state and registers hold; wait states on s_valid are unbounded.
- WRITE:
  - Lasts exactly one cycle, with s_ready=0, mem_we=1, mem_waddr=address, mem_wdata=assembled word.
  - mem_we rises the cycle after the 4th byte handshake (latency 1).
  - On exit: address+1 (wraps modulo 2**ADDR_W, so 1023 -> 0), words_left-1.
  - If words_left becomes 0, go to DONE; else go to LOAD.
- DONE: done=1 for exactly one cycle, s_ready=0, then IDLE.
- mem_waddr and mem_wdata are don't-care when mem_we=0; the implementation drives 0.
- Peak throughput: 5 cycles per word (4 byte handshakes + 1 write).
- start while not in IDLE is ignored, including start in DONE.
- Bytes arriving while s_ready=0 are not consumed; the source holds them.
- A rst during LOAD discards the partial word and issues no write. A rst during WRITE suppresses that mem_we.
- A load of 1024 words starting at any base wraps and writes every location exactly once.

Test Plan:
- Reset, then start with base_word=0, num_words=1, bytes 0x13,0x00,0x50,0x00 -> one mem_we pulse, waddr=0, wdata=0x00500013, 1 cycle after the 4th byte; done pulses the next cycle; core_hold falls with done.
- base_word=5, num_words=3, 12 back-to-back bytes 0x00..0x0B -> writes 5:0x03020100, 6:0x07060504, 7:0x0B0A0908; mem_we every 5th cycle; s_ready low during each WRITE.
- Random s_valid gaps (0-7 idle cycles between bytes), num_words=4 -> same data and addresses as the gap-free run; no extra or missing mem_we.
- base_word=1022, num_words=3 -> writes to addresses 1022, 1023, 0 in that order.
- num_words=0 -> no mem_we, s_ready stays 0, done pulses 1 cycle after start. Also: start pulsed mid-load -> ignored, and the load completes with the original base and count.
- Assert rst after 2 bytes of a word, then start a new load with base_word=9 and bytes 0xAA,0xBB,0xCC,0xDD -> no write from the aborted load; single write 9:0xDDCCBBAA.

Source files
------------

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module   : imem_loader_if
// Brief    : Control, byte-stream and memory-write bundle between a boot/debug
//            host and the instruction-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  // load request
  logic              start;
  logic [ADDR_W-1:0] base_word;
  logic [ADDR_W:0]   num_words;

  // little-endian byte stream
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;

  // instruction memory write port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  // status
  logic              busy;
  logic              core_hold;
  logic              done;

  // Host / stream source side
  modport master (
    output start, base_word, num_words, s_valid, s_data,
    input  s_ready, mem_we, mem_waddr, mem_wdata, busy, core_hold, done
  );

  // Loader side
  modport slave (
    input  start, base_word, num_words, s_valid, s_data,
    output s_ready, mem_we, mem_waddr, mem_wdata, busy, core_hold, done
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Packs a little-endian byte stream into 32-bit words and writes
//            them into the instruction memory from a programmable word index,
//            holding the core in reset while the program is loaded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // words_left value meaning "the word being written now is the final one"
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(1);

  state_t            state;
  logic [1:0]        byte_idx;
  logic [31:0]       word;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   words_left;

  // registered copies of every output
  logic              s_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [31:0]       mem_wdata_q;
  logic              busy_q;
  logic              core_hold_q;
  logic              done_q;

  logic              handshake;

  assign handshake = bus.s_valid && s_ready_q;

  // Load sequencer: all state and outputs are registered here, so each
  // output already reflects the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      byte_idx    <= 2'd0;
      word        <= '0;
      addr        <= '0;
      words_left  <= '0;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      core_hold_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            addr        <= bus.base_word;
            words_left  <= bus.num_words;
            byte_idx    <= 2'd0;
            core_hold_q <= 1'b1;
            if (bus.num_words == '0) begin
              // empty load: nothing to stream, just report completion
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state     <= LOAD;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (handshake) begin
            word[{byte_idx, 3'b000} +: 8] <= bus.s_data;
            if (byte_idx == 2'd3) begin
              // the fourth byte bypasses the word register straight into
              // the write data so the write lands one cycle after it
              byte_idx    <= 2'd0;
              state       <= WRITE;
              s_ready_q   <= 1'b0;
              mem_we_q    <= 1'b1;
              mem_waddr_q <= addr;
              mem_wdata_q <= {bus.s_data, word[23:0]};
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        WRITE: begin
          mem_we_q    <= 1'b0;
          mem_waddr_q <= '0;
          mem_wdata_q <= '0;
          // address wraps naturally at the memory depth
          addr        <= addr + 1'b1;
          words_left  <= words_left - 1'b1;
          if (words_left == LAST_WORD) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state     <= LOAD;
            s_ready_q <= 1'b1;
          end
        end

        DONE: begin
          // start is deliberately not looked at here
          done_q      <= 1'b0;
          core_hold_q <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  // a reset arriving in the write cycle must not commit the word
  assign bus.mem_we    = mem_we_q & ~rst;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.core_hold = core_hold_q;
  assign bus.done      = done_q;

  // Structural invariants of the sequencer outputs.
  a_no_ready_in_write : assert property (@(posedge clk) disable iff (rst)
    mem_we_q |-> !s_ready_q);
  a_done_not_busy     : assert property (@(posedge clk) disable iff (rst)
    done_q |-> (!busy_q && core_hold_q));
  a_busy_holds_core   : assert property (@(posedge clk) disable iff (rst)
    busy_q |-> core_hold_q);

endmodule

`default_nettype wire
